pipearch_c1_arbiter: RTL and testbench
======================================

# pipearch_c1_arbiter

Shares the single CCI-P c1 (write) TX channel between NUM_REQ write requesters, such as several writeback engines running concurrently. Round-robin arbitration; the requester ID is stamped into the header mdata field. Write responses arriving on c1 RX are routed back to the requester that issued them. Per-requester outstanding-write counters provide flow control and a drain indication for op_done logic.

## Interface
- NUM_REQ, 2, number of requesters; legal range 1..16.
- MAX_OUTSTANDING, 64, per-requester cap on issued but unacknowledged writes; legal range 1..65535.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- c1TxAlmFull  in  1  CCI-P c1 TX almost-full.
- req_valid  in  [NUM_REQ]  requester i presents a write.
- req_hdr  in  [NUM_REQ] x t_cci_c1_ReqMemHdr  write header; cl_len must be eCL_LEN_1.
- req_data  in  [NUM_REQ] x 512  write data.
- req_ready  out  [NUM_REQ]  one-hot grant, combinational; transfer occurs when req_valid[i] && req_ready[i].
- af2cp_sTx_c1  out  t_if_ccip_c1_Tx  registered c1 request to the FIU.
- cp2af_sRx_c1  in  t_if_ccip_c1_Rx  c1 responses.
- rsp_valid  out  [NUM_REQ]  one-cycle write-ack pulse for requester i.
- outstanding  out  [NUM_REQ] x 16  current unacknowledged count per requester.
- req_idle  out  [NUM_REQ]  outstanding[i] == 0.
- err_unexpected_ack  out  1  sticky; set on an ack for a requester with zero outstanding.

## Operation
- Eligible(i) = req_valid[i] && !c1TxAlmFull && outstanding[i] < MAX_OUTSTANDING.
- Grant: the first eligible index, searching upward from rr_ptr with wrap-around. At most one grant per cycle. No grant while c1TxAlmFull = 1.
- On transfer from requester g:
  - rr_ptr <= (g+1) mod NUM_REQ; rr_ptr is otherwise unchanged.
  - af2cp_sTx_c1.valid <= 1.
  - hdr <= req_hdr[g], with mdata[15:12] overwritten by g.
  - data <= req_data[g].
  - outstanding[g] increments.
- With no transfer, af2cp_sTx_c1.valid <= 0. hdr and data hold their values.
- Response path: when cp2af_sRx_c1.rspValid and hdr.resp_type == eRSP_WRLINE, let id = hdr.mdata[15:12].
  - If id < NUM_REQ and outstanding[id] > 0: rsp_valid[id] pulses and outstanding[id] decrements.
  - If id < NUM_REQ and outstanding[id] == 0: rsp_valid[id] still pulses, the counter is unchanged, and err_unexpected_ack is set.
  - If id >= NUM_REQ: no pulse is generated and err_unexpected_ack is set.
- Other response types (e.g. WRFENCE) are ignored.
- Same cycle issue and ack on the same requester: outstanding is unchanged (net 0).
- Counter never wraps. Issue is blocked at MAX_OUTSTANDING, and decrement is blocked at 0.
- Reset values:
  - af2cp_sTx_c1.valid = 0, rsp_valid = 0, outstanding = 0, req_idle = all 1, err_unexpected_ack = 0, rr_ptr = 0.
  - hdr and data are don't-care.
- Reset mid-operation clears all counters. Late acks for pre-reset writes then set err_unexpected_ack, which is intended.

## Timing
- req_ready is combinational from req_valid, c1TxAlmFull, the counters and rr_ptr, all in cycle N.
- A transfer in cycle N produces af2cp_sTx_c1.valid in cycle N+1, so issue latency is 1.
- outstanding and req_idle reflect an issue or ack from cycle N in cycle N+1.
- rspValid in cycle N produces rsp_valid in cycle N+1, so ack latency is 1.
- Sustained throughput is 1 line/cycle aggregate while c1TxAlmFull = 0.
- The FIU tolerates the few requests issued after almost-full rises. The block adds exactly one in-flight request beyond the gating cycle.
- A requester may hold req_valid while not granted. Data and header must stay stable until granted.

## Test plan
- Single requester, 4 writes back-to-back, then 4 acks:
  - af2cp valid on 4 consecutive cycles, with mdata[15:12] = 0.
  - outstanding[0] rises 1,2,3,4 then falls to 0.
  - req_idle[0] returns to 1.
- NUM_REQ = 2, both valid continuously for 6 cycles: grants alternate 0,1,0,1,0,1, and each write carries its own data and mdata id.
- c1TxAlmFull = 1 for 3 cycles with both valid: req_ready = 00 and no af2cp valid during those cycles. Issue resumes the cycle after almost-full drops.
- MAX_OUTSTANDING = 2, requester 0 issues 2 with no acks: req_ready[0] = 0 while requester 1 is still granted. One ack restores req_ready[0] on the next cycle.
- Issue and ack to requester 1 in the same cycle while outstanding[1] = 3: the count stays 3, and rsp_valid[1] pulses.
- Ack with mdata id 1 while outstanding[1] = 0, and separately an ack with id 5 (NUM_REQ = 2): err_unexpected_ack latches to 1 and stays set until reset.

Source files
------------

// File: rtl/pipearch_c1_arbiter.sv
`default_nettype none
// ==== pipearch_c1_arbiter : round-robin CCI-P c1 write arbiter with ack routing ====
// Rev 1.0 : initial release
module pipearch_c1_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c1TxAlmFull,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*80-1:0]  req_hdr,
  input  logic [NUM_REQ*512-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [592:0]           af2cp_sTx_c1,
  input  logic [28:0]            cp2af_sRx_c1,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [NUM_REQ*16-1:0]  outstanding,
  output logic [NUM_REQ-1:0]     req_idle,
  output logic                   err_unexpected_ack
);

  localparam int         c_HDR_W      = 80;
  localparam int         c_DATA_W     = 512;
  localparam int         c_PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] c_RSP_WRLINE = 4'h1;

  logic [c_PTR_W-1:0]  r_rr_ptr;
  logic                r_tx_valid;
  logic [c_HDR_W-1:0]  r_tx_hdr;
  logic [c_DATA_W-1:0] r_tx_data;
  logic                r_err;

  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [NUM_REQ-1:0]  w_ack_hit;
  logic [NUM_REQ-1:0]  w_ack_zero;
  logic [c_PTR_W-1:0]  w_gnt_idx;
  logic                w_any;
  logic [c_HDR_W-1:0]  w_sel_hdr;
  logic [c_DATA_W-1:0] w_sel_data;
  logic                w_ack_wr;
  logic [3:0]          w_ack_id;

  // Rx c1 layout: {hdr[27:0], rspValid}; hdr = {..., resp_type[3:0], mdata[15:0]}
  assign w_ack_wr = cp2af_sRx_c1[0] && (cp2af_sRx_c1[20:17] == c_RSP_WRLINE);
  assign w_ack_id = cp2af_sRx_c1[16:13];

  // Rotating priority: lowest eligible index at or above rr_ptr, else lowest overall.
  always_comb begin
    logic               w_hi_any;
    logic               w_lo_any;
    logic [c_PTR_W-1:0] w_hi_idx;
    logic [c_PTR_W-1:0] w_lo_idx;
    w_hi_any  = 1'b0;
    w_lo_any  = 1'b0;
    w_hi_idx  = '0;
    w_lo_idx  = '0;
    w_gnt     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = c_PTR_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_idx = c_PTR_W'(i);
        end
      end
    end
    w_any     = w_hi_any || w_lo_any;
    w_gnt_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    if (w_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_sel_hdr  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_hdr  = w_sel_hdr  | (req_hdr[i*c_HDR_W +: c_HDR_W]    & {c_HDR_W{w_gnt[i]}});
      w_sel_data = w_sel_data | (req_data[i*c_DATA_W +: c_DATA_W] & {c_DATA_W{w_gnt[i]}});
    end
    w_sel_hdr[15:12] = 4'(w_gnt_idx);
  end

  assign req_ready = w_gnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [15:0] r_cnt;
    logic        r_rsp;
    logic        w_inc;
    logic        w_dec;

    assign w_elig[i]     = req_valid[i] && !c1TxAlmFull && (r_cnt < 16'(MAX_OUTSTANDING));
    assign w_ack_hit[i]  = w_ack_wr && (w_ack_id == 4'(i));
    assign w_ack_zero[i] = w_ack_hit[i] && (r_cnt == 16'd0);
    assign w_inc         = w_gnt[i];
    assign w_dec         = w_ack_hit[i] && (r_cnt != 16'd0);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= 16'd0;
        r_rsp <= 1'b0;
      end else begin
        r_rsp <= w_ack_hit[i];
        if (w_inc && !w_dec)      r_cnt <= r_cnt + 16'd1;
        else if (w_dec && !w_inc) r_cnt <= r_cnt - 16'd1;
      end
    end

    assign outstanding[i*16 +: 16] = r_cnt;
    assign req_idle[i]             = (r_cnt == 16'd0);
    assign rsp_valid[i]            = r_rsp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_valid <= w_any;
      if (w_any) begin
        r_rr_ptr <= (w_gnt_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      // An ack for an id with no requester behind it is as unexpected as one for an idle requester.
      if ((|w_ack_zero) || (w_ack_wr && !(|w_ack_hit))) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_any) begin
      r_tx_hdr  <= w_sel_hdr;
      r_tx_data <= w_sel_data;
    end
  end

  assign af2cp_sTx_c1       = {r_tx_hdr, r_tx_data, r_tx_valid};
  assign err_unexpected_ack = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipearch_c1_arbiter.sv
`default_nettype none
// ==== tb_pipearch_c1_arbiter : randomized + directed bench against a cycle-level reference model ====
// Rev 1.0 : initial release
module tb_pipearch_c1_arbiter;

  localparam int NUM_REQ = 2;
  localparam int MAX_OUT = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   c1TxAlmFull = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ*80-1:0]  req_hdr = '0;
  logic [NUM_REQ*512-1:0] req_data = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [592:0]           af2cp_sTx_c1;
  logic [28:0]            cp2af_sRx_c1 = '0;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ*16-1:0]  outstanding;
  logic [NUM_REQ-1:0]     req_idle;
  logic                   err_unexpected_ack;

  pipearch_c1_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .c1TxAlmFull(c1TxAlmFull),
    .req_valid(req_valid), .req_hdr(req_hdr), .req_data(req_data), .req_ready(req_ready),
    .af2cp_sTx_c1(af2cp_sTx_c1), .cp2af_sRx_c1(cp2af_sRx_c1), .rsp_valid(rsp_valid),
    .outstanding(outstanding), .req_idle(req_idle), .err_unexpected_ack(err_unexpected_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: per-requester counts, round-robin start, sticky error.
  int m_cnt[NUM_REQ];
  int m_rr;
  bit m_err;
  int last_gnt;

  task automatic check_eq(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] t;
    for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom();
    return t;
  endfunction

  task automatic set_ack(input bit v, input logic [3:0] typ, input logic [3:0] id);
    logic [31:0] r;
    r = $urandom();
    cp2af_sRx_c1        = '0;
    cp2af_sRx_c1[0]     = v;
    cp2af_sRx_c1[12:1]  = r[11:0];
    cp2af_sRx_c1[16:13] = id;
    cp2af_sRx_c1[20:17] = typ;
    cp2af_sRx_c1[28:21] = r[31:24];
  endtask

  task automatic set_req(input int i, input bit v);
    req_valid[i]            = v;
    req_hdr[i*80 +: 80]     = rnd80();
    req_data[i*512 +: 512]  = rnd512();
  endtask

  // One clock cycle: inputs already driven at the falling edge.
  task automatic step();
    int                 eg;
    int                 inc[NUM_REQ];
    int                 dec[NUM_REQ];
    logic [NUM_REQ-1:0] e_rdy;
    logic [NUM_REQ-1:0] e_rsp;
    logic               e_txv;
    logic [79:0]        e_hdr;
    logic [511:0]       e_data;
    int                 id;
    #1;
    eg = -1;
    if (!c1TxAlmFull) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int cand;
        cand = (m_rr + k) % NUM_REQ;
        if (eg < 0 && req_valid[cand] && m_cnt[cand] < MAX_OUT) eg = cand;
      end
    end
    e_rdy = '0;
    if (eg >= 0) e_rdy[eg] = 1'b1;
    check_eq("req_ready", 600'(req_ready), 600'(e_rdy));
    last_gnt = eg;

    e_rsp = '0;
    for (int k = 0; k < NUM_REQ; k++) begin inc[k] = 0; dec[k] = 0; end
    if (cp2af_sRx_c1[0] && cp2af_sRx_c1[20:17] == 4'h1) begin
      id = int'(cp2af_sRx_c1[16:13]);
      if (id < NUM_REQ) begin
        e_rsp[id] = 1'b1;
        if (m_cnt[id] == 0) m_err = 1'b1;
        else dec[id] = 1;
      end else begin
        m_err = 1'b1;
      end
    end
    e_txv  = (eg >= 0);
    e_hdr  = '0;
    e_data = '0;
    if (eg >= 0) begin
      e_hdr        = req_hdr[eg*80 +: 80];
      e_hdr[15:12] = 4'(eg);
      e_data       = req_data[eg*512 +: 512];
      inc[eg]      = 1;
      m_rr         = (eg + 1) % NUM_REQ;
    end
    for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = m_cnt[k] + inc[k] - dec[k];

    @(posedge clk);
    #1;
    cp2af_sRx_c1 = '0;
    check_eq("tx_valid", 600'(af2cp_sTx_c1[0]), 600'(e_txv));
    if (e_txv) begin
      check_eq("tx_hdr", 600'(af2cp_sTx_c1[592:513]), 600'(e_hdr));
      check_eq("tx_data", 600'(af2cp_sTx_c1[512:1]), 600'(e_data));
    end
    check_eq("rsp_valid", 600'(rsp_valid), 600'(e_rsp));
    for (int k = 0; k < NUM_REQ; k++) begin
      check_eq("outstanding", 600'(outstanding[k*16 +: 16]), 600'(m_cnt[k]));
      check_eq("req_idle", 600'(req_idle[k]), 600'(m_cnt[k] == 0));
    end
    check_eq("err_ack", 600'(err_unexpected_ack), 600'(m_err));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    req_valid    = '0;
    c1TxAlmFull  = 1'b0;
    cp2af_sRx_c1 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_txv", 600'(af2cp_sTx_c1[0]), 600'(0));
    check_eq("rst_rsp", 600'(rsp_valid), 600'(0));
    check_eq("rst_out", 600'(outstanding), 600'(0));
    check_eq("rst_idle", 600'(req_idle), 600'({NUM_REQ{1'b1}}));
    check_eq("rst_err", 600'(err_unexpected_ack), 600'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = 0;
    m_rr     = 0;
    m_err    = 1'b0;
    last_gnt = -1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single requester: 4 back-to-back writes then 4 acks.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1);
      step();
      check_eq("single_cnt", 600'(outstanding[15:0]), 600'(k + 1));
      check_eq("single_id", 600'(af2cp_sTx_c1[528:525]), 600'(0));
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      set_ack(1'b1, 4'h1, 4'd0);
      step();
      check_eq("single_dec", 600'(outstanding[15:0]), 600'(3 - k));
    end
    check_eq("single_idle", 600'(req_idle[0]), 600'(1));

    // Both valid: alternating grants starting at 0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 0 || last_gnt == 0) set_req(0, 1'b1);
      if (k == 0 || last_gnt == 1) set_req(1, 1'b1);
      step();
      check_eq("alt_id", 600'(af2cp_sTx_c1[528:525]), 600'(k % 2));
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      set_ack(1'b1, 4'h1, 4'(k % 2));
      step();
    end

    // Almost-full gating for 3 cycles, then resume.
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    c1TxAlmFull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("almf_rdy", 600'(req_ready), 600'(0));
      step();
      check_eq("almf_txv", 600'(af2cp_sTx_c1[0]), 600'(0));
    end
    c1TxAlmFull = 1'b0;
    step();
    check_eq("almf_resume", 600'(af2cp_sTx_c1[0]), 600'(1));

    // Cap: requester 0 saturates, requester 1 still served, one ack re-enables 0.
    do_reset();
    for (int k = 0; k < MAX_OUT; k++) begin
      set_req(0, 1'b1);
      step();
    end
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    set_ack(1'b1, 4'h1, 4'd0);
    #1;
    check_eq("cap_rdy", 600'(req_ready), 600'(2'b10));
    step();
    #1;
    check_eq("cap_restore", 600'(req_ready), 600'(2'b01));
    step();

    // Same-cycle issue and ack on requester 1 at count 3.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1);
      step();
    end
    set_req(1, 1'b1);
    set_ack(1'b1, 4'h1, 4'd1);
    step();
    check_eq("net0_cnt", 600'(outstanding[31:16]), 600'(3));
    check_eq("net0_rsp", 600'(rsp_valid[1]), 600'(1));

    // Randomized traffic with a mid-run reset; acks only for writes in flight.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int r;
      if (c == 200) do_reset();
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] || last_gnt == i) set_req(i, $urandom_range(0, 3) != 0);
      c1TxAlmFull = ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        int s;
        s = int'($urandom_range(0, NUM_REQ - 1));
        for (int k = 0; k < NUM_REQ; k++) begin
          int cand;
          cand = (s + k) % NUM_REQ;
          if (!cp2af_sRx_c1[0] && m_cnt[cand] > 0) set_ack(1'b1, 4'h1, 4'(cand));
        end
      end else if (r == 5) begin
        set_ack(1'b1, 4'h4, 4'($urandom_range(0, 15)));
      end
      step();
    end
    req_valid   = '0;
    c1TxAlmFull = 1'b0;

    // Unexpected acks: idle requester, then out-of-range id.
    do_reset();
    set_ack(1'b1, 4'h1, 4'd1);
    step();
    check_eq("unexp_err", 600'(err_unexpected_ack), 600'(1));
    check_eq("unexp_rsp", 600'(rsp_valid), 600'(2'b10));
    for (int k = 0; k < 3; k++) step();
    check_eq("unexp_sticky", 600'(err_unexpected_ack), 600'(1));
    do_reset();
    set_ack(1'b1, 4'h1, 4'd5);
    step();
    check_eq("badid_err", 600'(err_unexpected_ack), 600'(1));
    check_eq("badid_rsp", 600'(rsp_valid), 600'(0));
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
